// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: one full_adder slice, LSB-first, carry held in a flop between bits.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);
    assign s = a ^ b ^ cin;
    assign c = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   sum_sr;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt;
    logic               s_bit;
    logic               c_bit;
    logic [WIDTH-1:0]   b_load;
    logic               carry_load;

    full_adder u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (carry_q),
        .s   (s_bit),
        .c   (c_bit)
    );

    // Subtraction is a + ~b + 1, so only the loaded operand and carry differ.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr    <= a;
                        b_sr    <= b_load;
                        carry_q <= carry_load;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    sum_sr  <= {s_bit, sum_sr[WIDTH-1:1]};
                    a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
                    carry_q <= c_bit;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags decode from state only; no path from in_valid/out_ready.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
    assign sum       = sum_sr;
    assign cout      = carry_q;

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Directed bench for serial_adder_fsm (WIDTH=8): vector table plus handshake,
// backpressure, mid-run reset and back-to-back sequences.

module tb_serial_adder_fsm;
    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_checks;
    int n_fail;
    int cyc;

    serial_adder_fsm #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Issue one operation, wait for the result, then complete the output handshake.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tcin,
                          output logic [W-1:0] rs, output logic rc, output int lat);
        int n;
        @(negedge clk);
        a = ta; b = tb_; cin = tcin; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 50);
        rs = sum;
        rc = cout;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] rs;
        logic         rc;
        int           lat;
        int           n;
        int           acc;
        int           prev;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rcin;
        logic [W:0]   model;

        n_checks = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b0;

        vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
        vecs[6] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
        vecs[7] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_valid", int'(out_valid), 0);
        check("reset busy", int'(busy), 0);
        check("reset sum", int'(sum), 0);
        check("reset cout", int'(cout), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vcin, rs, rc, lat);
            check($sformatf("vec%0d sum", i), int'(rs), int'(vecs[i].exp_sum));
            check($sformatf("vec%0d cout", i), int'(rc), int'(vecs[i].exp_cout));
            check($sformatf("vec%0d latency", i), lat, W);
        end

        // Backpressure: result held while new operands are presented and ignored.
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("bp busy in run", int'(busy), 1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp reached done", int'(out_valid), 1);
        a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp out_valid", int'(out_valid), 1);
            check("bp sum", int'(sum), 8'h46);
            check("bp cout", int'(cout), 0);
            check("bp in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp released out_valid", int'(out_valid), 0);
        check("bp released in_ready", int'(in_ready), 1);
        check("bp released busy", int'(busy), 0);

        // Reset in the middle of a computation.
        @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrun busy before reset", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midrun reset in_ready", int'(in_ready), 1);
        check("midrun reset busy", int'(busy), 0);
        check("midrun reset out_valid", int'(out_valid), 0);
        check("midrun reset sum", int'(sum), 0);
        check("midrun reset cout", int'(cout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h01, 8'h01, 1'b0, rs, rc, lat);
        check("after reset sum", int'(rs), 8'h02);
        check("after reset cout", int'(rc), 0);
        check("after reset latency", lat, W);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        run_op(8'h10, 8'h01, 1'b0, rs, rc, lat);
        check("sub 10-01 sum", int'(rs), 8'h0F);
        check("sub 10-01 cout", int'(rc), 1);
        run_op(8'h01, 8'h02, 1'b0, rs, rc, lat);
        check("sub 01-02 sum", int'(rs), 8'hFF);
        check("sub 01-02 cout", int'(rc), 0);
        sub = 1'b0;
`endif

        // Back-to-back with in_valid and out_ready held high.
        out_ready = 1'b1;
        prev = -1;
        for (int i = 0; i < 3; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rcin = 1'($urandom_range(0, 1));
            model = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rcin};
            @(negedge clk);
            a = ra; b = rb; cin = rcin; in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            acc = cyc + 1;
            if (i > 0) check("b2b interval", acc - prev, W + 2);
            prev = acc;
            @(posedge clk);
            #1;
            n = 0;
            while (!out_valid && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("b2b sum", int'(sum), int'(model[W-1:0]));
            check("b2b cout", int'(cout), int'(model[W]));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("b2b idle after", int'(in_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
